// File: rtl/shift_frame_sequencer.sv
// shift_frame_sequencer: round-robin arbiter + parallel-to-serial framer.
// Two requesters offer WIDTH-bit words. In IDLE one is granted. Its word is
// shifted out LSB- or MSB-first over WIDTH cycles, followed by GAP_CYCLES
// idle guard cycles.
module shift_frame_sequencer #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    input  logic [WIDTH-1:0] req_data0,
    input  logic [WIDTH-1:0] req_data1,
    input  logic [1:0]       req_dir,
    output logic [1:0]       req_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             granted_id,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] bit_cnt;
    logic [3:0]       gap_cnt;
    logic             last_grant;

    logic             winner;
    logic             accept;
    logic [WIDTH-1:0] win_data;
    logic             win_dir;
    logic [WIDTH-1:0] ordered;

    // Arbitration: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        winner = req_valid[1];
        if (&req_valid) winner = ~last_grant;
        req_ready = 2'b00;
        if (state == IDLE && !reset && |req_valid) req_ready[winner] = 1'b1;
        accept   = |req_ready;
        win_data = winner ? req_data1 : req_data0;
        win_dir  = req_dir[winner];
    end

    // Put the word into transmit order so the shifter always emits bit 0 next.
    always_comb begin
        ordered = '0;
        for (int i = 0; i < WIDTH; i++)
            ordered[i] = win_dir ? win_data[WIDTH-1-i] : win_data[i];
    end

    // Frame sequencer: all outputs registered. The first bit is launched on the accept edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            sreg         <= '0;
            bit_cnt      <= '0;
            gap_cnt      <= '0;
            last_grant   <= 1'b1;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            frame_start  <= 1'b0;
            frame_end    <= 1'b0;
            granted_id   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state        <= SHIFT;
                        sreg         <= ordered >> 1;
                        serial_out   <= ordered[0];
                        serial_valid <= 1'b1;
                        frame_start  <= 1'b1;
                        busy         <= 1'b1;
                        bit_cnt      <= '0;
                        granted_id   <= winner;
                        last_grant   <= winner;
                    end else begin
                        serial_out   <= 1'b0;
                        serial_valid <= 1'b0;
                        busy         <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bit_cnt == CNT_W'(WIDTH-1)) begin
                        // The last bit is on the line now; close the frame.
                        bit_cnt      <= '0;
                        serial_out   <= 1'b0;
                        serial_valid <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            state   <= GAP;
                            gap_cnt <= 4'(GAP_CYCLES-1);
                            busy    <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        bit_cnt    <= bit_cnt + 1'b1;
                        serial_out <= sreg[0];
                        sreg       <= sreg >> 1;
                        frame_end  <= (bit_cnt == CNT_W'(WIDTH-2));
                    end
                end
                GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/shift_frame_sequencer.md
Name: shift_frame_sequencer

Overview:
- Serializes parallel words from two requesters onto one serial line, one frame at a time.
- Arbitrates round-robin between requesters and sequences the shift (load, WIDTH shift cycles, guard gap).
- Each frame selects LSB-first or MSB-first order.
- Sits upstream of serial links, in front of SISO shift-register stages.

Parameters:
- WIDTH, 8, bits per frame; legal range 2..32.
- GAP_CYCLES, 2, idle guard cycles after each frame's last bit; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  2  per-requester word valid; bit i = requester i.
- req_data0  input  WIDTH  requester 0 word.
- req_data1  input  WIDTH  requester 1 word.
- req_dir  input  2  per-requester shift order; 0 = LSB first, 1 = MSB first.
- req_ready  output  2  per-requester accept strobe; combinational.
- serial_out  output  1  serial data bit; registered.
- serial_valid  output  1  high while serial_out carries a frame bit; registered.
- frame_start  output  1  one-cycle pulse with the first bit of a frame.
- frame_end  output  1  one-cycle pulse with the last bit of a frame.
- granted_id  output  1  requester owning the current frame; held until next grant.
- busy  output  1  high in SHIFT or GAP.

Behaviour:
- Reset (sync, active-high, sampled on posedge clk): state=IDLE, shift register=0, bit_cnt=0, last_grant=1.
- All registered outputs reset to 0: serial_out, serial_valid, frame_start, frame_end, granted_id, busy.
- req_ready=0 while reset is high.
- Reset mid-frame aborts the frame. The remaining bits are discarded, outputs read 0 the cycle after the reset edge, and no frame_end is issued.
- States: IDLE, SHIFT, GAP.
- Arbitration, IDLE only:
  - Exactly one req_valid bit set: that requester wins.
  - Both set: the requester != last_grant wins.
  - req_ready[w] = (state==IDLE) & req_valid[w] & ~reset; the other req_ready bit is 0.
  - req_ready is never high outside IDLE.
- Acceptance occurs at the edge where req_valid[i] & req_ready[i] = 1 (cycle T). At that edge:
  - Capture the winner's data and dir.
  - Set last_grant and granted_id to the winner.
  - State goes to SHIFT.
- SHIFT, cycles T+1 .. T+WIDTH:
  - serial_valid=1, busy=1.
  - serial_out = data[k] for dir=0, data[WIDTH-1-k] for dir=1, where k = bit_cnt = 0..WIDTH-1.
  - frame_start=1 only at T+1; frame_end=1 only at T+WIDTH.
  - Latency from acceptance edge to first bit: 1 cycle.
- After the last bit:
  - GAP_CYCLES>0: GAP for exactly GAP_CYCLES cycles, then IDLE. In GAP, serial_valid=0, serial_out=0, busy=1.
  - GAP_CYCLES=0: go directly to IDLE.
- IDLE: serial_valid=0, serial_out=0, busy=0.
- Throughput: next acceptance is at the earliest edge T+WIDTH+GAP_CYCLES+1. Its first bit appears at T+WIDTH+GAP_CYCLES+2, so every frame is followed by at least one non-valid cycle.
- Requesters hold req_valid and data stable until accepted. A valid dropped before acceptance is ignored, with no side effects.
- Input changes during SHIFT/GAP do not affect the frame in flight.
- bit_cnt is $clog2(WIDTH) bits wide and never wraps mid-frame; it clears on frame end.
- Both requesters valid on every IDLE cycle: grants alternate 0,1,0,1.

Test Plan:
- Reset, then req_valid=2'b01, req_data0=8'hC1, req_dir[0]=0, accept at T → serial_out 1,0,0,0,0,0,1,1 on T+1..T+8. frame_start at T+1, frame_end at T+8, granted_id=0, busy low from T+11 (GAP=2).
- Same word with req_dir[0]=1 → serial_out 1,1,0,0,0,0,0,1; all pulse timing identical.
- Both valid after reset (data0=8'h0F, data1=8'hF0, dir=0) → req0 accepted first, req_ready[1]=0 until edge T+11. Then req1 frame 0,0,0,0,1,1,1,1 with granted_id=1.
- Both held valid for 4 frames → grant order 0,1,0,1. Exactly one req_ready bit high per accept, never high while busy=1.
- Reset asserted at 4th bit of a frame → next cycle all outputs 0, state IDLE. A subsequent dual request grants req0 (last_grant=1 after reset).
- GAP_CYCLES=0, req0 held valid → frame_end at T+8, re-accept at edge T+9, next frame_start at T+10, serial_valid low only at T+9.
